// File: rtl/aes_pkg.sv
// Shared AES-128 decrypt definitions: round count, FSM encoding, round-key slicing,
// inverse S-box and GF(2^8) helpers used by the iterative inverse cipher.
package aes_pkg;

    localparam int unsigned NR = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } fsm_e;

    // Round key 0 occupies the top 128 bits of the expanded-key bus.
    function automatic logic [127:0] rk(input logic [1407:0] keys, input logic [3:0] r);
        return keys[1407 - 128*int'(r) -: 128];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] s;
        s = '0;
        case (x)
            8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5; 8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
            8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e; 8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
            8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82; 8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
            8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44; 8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
            8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32; 8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
            8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b; 8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
            8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66; 8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
            8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49; 8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
            8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64; 8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
            8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc; 8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
            8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50; 8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
            8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57; 8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
            8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00; 8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
            8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05; 8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
            8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f; 8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
            8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03; 8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
            8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41; 8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
            8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce; 8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
            8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22; 8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
            8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8; 8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
            8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71; 8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
            8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e; 8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
            8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b; 8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
            8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe; 8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
            8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33; 8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
            8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59; 8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
            8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9; 8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
            8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f; 8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
            8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d; 8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
            8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c; 8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
            8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e; 8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
            8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63; 8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
            default: s = '0;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // One state column, byte 0 (row 0) in the top bits.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3),
                mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3),
                mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3),
                mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3)};
    endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// Request/response bundle of the iterative AES-128 inverse cipher.
interface aes_inv_cipher_iter_if;
    logic          start;
    logic [127:0]  ciphertext;
    logic [1407:0] round_keys;
    logic [127:0]  plaintext;
    logic          busy;
    logic          done;

    modport master (
        output start, ciphertext, round_keys,
        input  plaintext, busy, done
    );

    modport slave (
        input  start, ciphertext, round_keys,
        output plaintext, busy, done
    );
endinterface

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// unless is_final, InvMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] key_in,
    input  logic         is_final,
    output logic [127:0] state_out
);

    logic [127:0] subbed;
    logic [127:0] added;
    logic [127:0] mixed;

    // Row r of column c comes from column (c - r) mod 4 of the input.
    always_comb begin
        subbed = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                subbed[127 - 8*(c*4 + r) -: 8] =
                    inv_sbox(state_in[127 - 8*(((c + 4 - r) % 4)*4 + r) -: 8]);
            end
        end
    end

    assign added = subbed ^ key_in;

    always_comb begin
        mixed = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            mixed[127 - 32*c -: 32] = inv_mix_col(added[127 - 32*c -: 32]);
        end
    end

    assign state_out = is_final ? added : mixed;

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, 10 cycles from accept to done,
// driven by the shared 1408-bit expanded-key bus.
module aes_inv_cipher_iter
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    aes_inv_cipher_iter_if.slave bus
);

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] state_q, state_d;
    logic [127:0] plaintext_q, plaintext_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [127:0] round_key;
    logic [127:0] round_out;

    // The final round runs with rnd_q == 0, so the same slice serves rk0.
    assign round_key = rk(bus.round_keys, rnd_q);

    aes_inv_round u_round (
        .state_in  (state_q),
        .key_in    (round_key),
        .is_final  (fsm_q == FINAL),
        .state_out (round_out)
    );

    always_comb begin
        fsm_d       = fsm_q;
        rnd_d       = rnd_q;
        state_d     = state_q;
        plaintext_d = plaintext_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = bus.ciphertext ^ rk(bus.round_keys, 4'(NR));
                    rnd_d   = 4'(NR - 1);
                    busy_d  = 1'b1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                state_d = round_out;
                rnd_d   = rnd_q - 4'd1;
                if (rnd_q <= 4'd1) begin
                    fsm_d = FINAL;
                end
            end
            FINAL: begin
                plaintext_d = round_out;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                fsm_d       = IDLE;
            end
            default: begin
                busy_d = 1'b0;
                fsm_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            rnd_q       <= '0;
            state_q     <= '0;
            plaintext_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            rnd_q       <= rnd_d;
            state_q     <= state_d;
            plaintext_q <= plaintext_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.plaintext = plaintext_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Self-checking bench for aes_inv_cipher_iter: FIPS-197 vectors, back-to-back, mid-block
// reset and random round trips through an independent forward-cipher model.
module tb_aes_inv_cipher_iter;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [7:0]   sbox [256];
    logic [127:0] exp_q [$];

    aes_inv_cipher_iter_if bus ();

    aes_inv_cipher_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // Forward S-box from the GF(2^8) inverse plus the affine map.
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x] = s;
        end
    endtask

    function automatic logic [1407:0] expand_key(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1407:0] out;
        rcon = 8'h01;
        out  = '0;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) out[1407 - 32*i -: 32] = w[i];
        return out;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1407:0] rks);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] st;
        st = pt ^ rks[1407 -: 128];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[st[127 - 8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) t[c*4 + w] = s[((c + w) % 4)*4 + w];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[c*4]; a1 = t[c*4+1]; a2 = t[c*4+2]; a3 = t[c*4+3];
                    t[c*4]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    t[c*4+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    t[c*4+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    t[c*4+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) st[127 - 8*i -: 8] = t[i];
            st = st ^ rks[1407 - 128*r -: 128];
        end
        return st;
    endfunction

    // Drive one accept and wait (bounded) for done; lat = -1 on timeout.
    task automatic run_block(input logic [127:0] ct, output int lat, output logic busy_e0);
        bus.ciphertext = ct;
        bus.start      = 1'b1;
        @(negedge clk);
        busy_e0   = bus.busy;
        bus.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (bus.plaintext !== 128'h0) begin errors++; $display("FAIL reset_plaintext got %h want 0", bus.plaintext); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL idle_no_start busy %b done %b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_vector(input string name, input logic [127:0] key,
                               input logic [127:0] ct, input logic [127:0] pt);
        int lat;
        logic b0;
        logic [127:0] exp;
        bus.round_keys = expand_key(key);
        exp_q.push_back(pt);
        run_block(ct, lat, b0);
        exp = exp_q.pop_front();
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL %s_busy_after_accept got %b want 1", name, b0); end
        checks++; if (lat != 10) begin errors++; $display("FAIL %s_latency got %0d want 10", name, lat); end
        checks++; if (bus.plaintext !== exp) begin errors++; $display("FAIL %s_plaintext got %h want %h", name, bus.plaintext, exp); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s_busy_at_done got %b want 0", name, bus.busy); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL %s_done_width got %b want 0", name, bus.done); end
    endtask

    task automatic test_back_to_back();
        int n;
        int want_cyc;
        logic [127:0] exp;
        logic [1407:0] rk_b;
        rk_b = expand_key(KEY_B);
        exp_q.push_back(PT_C1);
        exp_q.push_back(PT_B);
        bus.round_keys = expand_key(KEY_C1);
        bus.ciphertext = CT_C1;
        bus.start      = 1'b1;
        n = 0;
        for (int c = 0; c <= 30 && n < 2; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 9) bus.ciphertext = {$urandom, $urandom, $urandom, $urandom};
            if (bus.done) begin
                want_cyc = (n == 0) ? 10 : 21;
                exp = exp_q.pop_front();
                checks++; if (c != want_cyc) begin errors++; $display("FAIL b2b_done_cycle got %0d want %0d", c, want_cyc); end
                checks++; if (bus.plaintext !== exp) begin errors++; $display("FAIL b2b_plaintext got %h want %h", bus.plaintext, exp); end
                n++;
                if (n == 1) begin
                    bus.round_keys = rk_b;
                    bus.ciphertext = CT_B;
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        checks++; if (n != 2) begin
            errors++; $display("FAIL b2b_timeout got %0d done pulses want 2", n);
            exp_q.delete();
        end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_no_third_accept busy %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic b0;
        logic [127:0] exp;
        bus.round_keys = expand_key(KEY_C1);
        bus.ciphertext = CT_C1;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", bus.done); end
        checks++; if (bus.plaintext !== 128'h0) begin errors++; $display("FAIL rstmid_plaintext got %h want 0", bus.plaintext); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.round_keys = expand_key(KEY_B);
        exp_q.push_back(PT_B);
        run_block(CT_B, lat, b0);
        exp = exp_q.pop_front();
        checks++; if (lat != 10) begin errors++; $display("FAIL rstmid_latency got %0d want 10", lat); end
        checks++; if (bus.plaintext !== exp) begin errors++; $display("FAIL rstmid_plaintext_after got %h want %h", bus.plaintext, exp); end
    endtask

    task automatic test_round_trip();
        int lat;
        logic b0;
        logic [127:0] key, pt, ct, exp;
        logic [1407:0] rks;
        for (int i = 0; i < 1000; i++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            rks = expand_key(key);
            ct  = encrypt(pt, rks);
            bus.round_keys = rks;
            exp_q.push_back(pt);
            run_block(ct, lat, b0);
            exp = exp_q.pop_front();
            checks++; if (lat != 10) begin errors++; $display("FAIL rt_latency[%0d] got %0d want 10", i, lat); end
            checks++; if (bus.plaintext !== exp) begin errors++; $display("FAIL rt_plaintext[%0d] got %h want %h", i, bus.plaintext, exp); end
            @(negedge clk);
            checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rt_done_width[%0d] got %b want 0", i, bus.done); end
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.ciphertext = '0;
        bus.round_keys = '0;
        build_sbox();
        repeat (3) @(negedge clk);
        test_reset();
        test_vector("fips_c1", KEY_C1, CT_C1, PT_C1);
        test_vector("fips_b", KEY_B, CT_B, PT_B);
        test_back_to_back();
        test_reset_mid();
        test_round_trip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
